// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage. Issues one data-memory access at a
// time over a req/ack handshake, aligns store lanes, extracts and extends load
// data, and registers the MEM/WB payload for the writeback mux.
module mem_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_link_pc,
    input  logic [31:0] ex_aluresult,
    input  logic [31:0] ex_storedata,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [2:0]  ex_funct3,
    input  logic [1:0]  ex_memtoreg,
    input  logic        ex_regwrite,
    input  logic [4:0]  ex_rd,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_reg_pc,
    output logic [31:0] wb_readdata,
    output logic [31:0] wb_aluresult,
    output logic [1:0]  wb_memtoreg,
    output logic        wb_regwrite,
    output logic [4:0]  wb_rd,
    output logic        mem_misaligned,
    output logic        mem_timeout
);

    localparam logic [7:0] LP_CNT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [7:0]  r_cnt;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [1:0]  r_addr_lo;
    logic [2:0]  r_funct3;
    logic        r_is_load;

    logic        r_wb_valid;
    logic [31:0] r_wb_reg_pc;
    logic [31:0] r_wb_readdata;
    logic [31:0] r_wb_aluresult;
    logic [1:0]  r_wb_memtoreg;
    logic        r_wb_regwrite;
    logic [4:0]  r_wb_rd;
    logic        r_misaligned;
    logic        r_timeout;

    logic        w_memop;
    logic        w_aligned;
    logic        w_accept;
    logic        w_misalign;
    logic        w_cnt_last;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;

    assign w_memop    = ex_valid & (ex_memread | ex_memwrite);
    assign w_accept   = (r_state == S_IDLE) & w_memop & w_aligned;
    assign w_misalign = (r_state == S_IDLE) & w_memop & ~w_aligned;
    assign w_cnt_last = (r_cnt == LP_CNT_LAST);

    // Alignment check and store lane generation from funct3[1:0] and address.
    always_comb begin
        w_aligned = 1'b0;
        w_be      = 4'b1111;
        w_wdata   = '0;
        case (ex_funct3[1:0])
            2'b00:   w_aligned = 1'b1;
            2'b01:   w_aligned = ~ex_aluresult[0];
            default: w_aligned = (ex_aluresult[1:0] == 2'b00);
        endcase
        // memread has priority, so a store is only memwrite without memread
        if (!ex_memread) begin
            case (ex_funct3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << ex_aluresult[1:0];
                    w_wdata = {4{ex_storedata[7:0]}};
                end
                2'b01: begin
                    w_be    = ex_aluresult[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{ex_storedata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = ex_storedata;
                end
            endcase
        end
    end

    // Load extraction: pick lane by registered address, extend by funct3.
    always_comb begin
        w_ld_byte = '0;
        case (r_addr_lo)
            2'd0: w_ld_byte = dmem_rdata[7:0];
            2'd1: w_ld_byte = dmem_rdata[15:8];
            2'd2: w_ld_byte = dmem_rdata[23:16];
            2'd3: w_ld_byte = dmem_rdata[31:24];
            default: w_ld_byte = '0;
        endcase
        w_ld_half = r_addr_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (r_funct3[1:0])
            2'b00:   w_ld_data = {{24{~r_funct3[2] & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_ld_data = {{16{~r_funct3[2] & w_ld_half[15]}}, w_ld_half};
            default: w_ld_data = dmem_rdata;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: accept aligned memory ops, leave WAIT on ack or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
            S_WAIT: if (dmem_ack || w_cnt_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: stall upstream while an access is pending.
    always_comb begin
        mem_stall = 1'b0;
        case (r_state)
            S_IDLE:  mem_stall = w_accept;
            S_WAIT:  mem_stall = ~dmem_ack & ~w_cnt_last;
            default: mem_stall = 1'b0;
        endcase
    end

    // Request registers, wait counter and MEM/WB payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= '0;
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_be           <= '0;
            r_wdata        <= '0;
            r_addr_lo      <= '0;
            r_funct3       <= '0;
            r_is_load      <= 1'b0;
            r_wb_valid     <= 1'b0;
            r_wb_reg_pc    <= '0;
            r_wb_readdata  <= '0;
            r_wb_aluresult <= '0;
            r_wb_memtoreg  <= '0;
            r_wb_regwrite  <= 1'b0;
            r_wb_rd        <= '0;
            r_misaligned   <= 1'b0;
            r_timeout      <= 1'b0;
        end else begin
            r_misaligned <= 1'b0;
            r_timeout    <= 1'b0;
            if (r_state == S_IDLE) begin
                r_wb_reg_pc    <= ex_link_pc;
                r_wb_aluresult <= ex_aluresult;
                r_wb_memtoreg  <= ex_memtoreg;
                r_wb_rd        <= ex_rd;
                r_wb_readdata  <= '0;
                if (w_accept) begin
                    r_req         <= 1'b1;
                    r_we          <= ~ex_memread;
                    r_addr        <= {ex_aluresult[31:2], 2'b00};
                    r_be          <= w_be;
                    r_wdata       <= w_wdata;
                    r_addr_lo     <= ex_aluresult[1:0];
                    r_funct3      <= ex_funct3;
                    r_is_load     <= ex_memread;
                    r_cnt         <= '0;
                    r_wb_valid    <= 1'b0;
                    r_wb_regwrite <= ex_regwrite;
                end else begin
                    r_wb_valid    <= ex_valid;
                    r_wb_regwrite <= ex_valid & ex_regwrite & ~w_misalign;
                    r_misaligned  <= w_misalign;
                end
            end else begin
                r_cnt <= r_cnt + 8'd1;
                if (dmem_ack) begin
                    r_req         <= 1'b0;
                    r_wb_valid    <= 1'b1;
                    r_wb_readdata <= r_is_load ? w_ld_data : '0;
                end else if (w_cnt_last) begin
                    r_req         <= 1'b0;
                    r_wb_valid    <= 1'b1;
                    r_wb_regwrite <= 1'b0;
                    r_timeout     <= 1'b1;
                end
            end
        end
    end

    assign dmem_req       = r_req;
    assign dmem_we        = r_we;
    assign dmem_addr      = r_addr;
    assign dmem_be        = r_be;
    assign dmem_wdata     = r_wdata;
    assign wb_valid       = r_wb_valid;
    assign wb_reg_pc      = r_wb_reg_pc;
    assign wb_readdata    = r_wb_readdata;
    assign wb_aluresult   = r_wb_aluresult;
    assign wb_memtoreg    = r_wb_memtoreg;
    assign wb_regwrite    = r_wb_regwrite;
    assign wb_rd          = r_wb_rd;
    assign mem_misaligned = r_misaligned;
    assign mem_timeout    = r_timeout;

endmodule
